// File: rtl/dcache_write_responder_if.sv
// Signal bundle between dcache_write_responder and its environment: store committer,
// tag/data arrays, MSHR and memory write port. The slave modport is the responder's view.
interface dcache_write_responder_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_BYTES  = 16,
    parameter int INDEX_WIDTH = 6
);
    localparam int OFFSET_WIDTH = $clog2(LINE_BYTES);
    localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;

    logic                     dcWriteReq;
    logic [ADDR_WIDTH-1:0]    dcWriteAddr;
    logic [8*LINE_BYTES-1:0]  dcWriteData;
    logic [LINE_BYTES-1:0]    dcWriteByteWE;
    logic                     dcWriteUncachable;
    logic                     dcWriteReqAck;
    logic                     dcWriteBusy;
    logic                     dcWriteHit;

    logic [INDEX_WIDTH-1:0]   tagReadIndex;
    logic [TAG_WIDTH:0]       tagReadData;

    logic                     dataWE;
    logic [INDEX_WIDTH-1:0]   dataWriteIndex;
    logic [8*LINE_BYTES-1:0]  dataWriteData;
    logic [LINE_BYTES-1:0]    dataWriteByteWE;

    logic                     mshrAllocReq;
    logic [ADDR_WIDTH-1:0]    mshrAllocAddr;
    logic                     mshrAllocAck;
    logic                     mshrFillDone;

    logic                     memWriteReq;
    logic [ADDR_WIDTH-1:0]    memWriteAddr;
    logic [8*LINE_BYTES-1:0]  memWriteData;
    logic [LINE_BYTES-1:0]    memWriteByteWE;
    logic                     memWriteAck;

    modport slave (
        input  dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE, dcWriteUncachable,
        output dcWriteReqAck, dcWriteBusy, dcWriteHit,
        output tagReadIndex,
        input  tagReadData,
        output dataWE, dataWriteIndex, dataWriteData, dataWriteByteWE,
        output mshrAllocReq, mshrAllocAddr,
        input  mshrAllocAck, mshrFillDone,
        output memWriteReq, memWriteAddr, memWriteData, memWriteByteWE,
        input  memWriteAck
    );

    modport master (
        output dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE, dcWriteUncachable,
        input  dcWriteReqAck, dcWriteBusy, dcWriteHit,
        input  tagReadIndex,
        output tagReadData,
        input  dataWE, dataWriteIndex, dataWriteData, dataWriteByteWE,
        input  mshrAllocReq, mshrAllocAddr,
        output mshrAllocAck, mshrFillDone,
        input  memWriteReq, memWriteAddr, memWriteData, memWriteByteWE,
        output memWriteAck
    );
endinterface

// File: rtl/dcache_write_responder.sv
// DCache store write responder: tag lookup, byte-masked line write, miss handling, uncachable writes.
// Define RSD_DCACHE_WRITE_ALLOCATE_EN to allocate on a store miss; otherwise misses write through.
module dcache_write_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_BYTES  = 16,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    dcache_write_responder_if.slave bus
);
    localparam int OFFSET_WIDTH = $clog2(LINE_BYTES);
    localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        WRITE,
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
        MISS_ALLOC,
        MISS_WAIT,
        RETAG,
`endif
        UC_WRITE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [8*LINE_BYTES-1:0] data_q, data_d;
    logic [LINE_BYTES-1:0]   be_q, be_d;
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
    logic                    fillSeen_q, fillSeen_d;
`endif

    logic                    accept;
    logic                    tagHit;
    logic                    writeLine;
    logic                    writeDone;
    logic                    allocReq;
    logic                    memReq;
    logic [INDEX_WIDTH-1:0]  tagIndex;

    assign tagHit = bus.tagReadData[TAG_WIDTH] &&
                    (bus.tagReadData[TAG_WIDTH-1:0] == addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
        fillSeen_d = fillSeen_q;
`endif
        accept     = 1'b0;
        writeLine  = 1'b0;
        writeDone  = 1'b0;
        allocReq   = 1'b0;
        memReq     = 1'b0;
        tagIndex   = '0;

        unique case (state_q)
            IDLE: begin
                // Acceptance is masked while reset is asserted so nothing is acked and then dropped.
                if (bus.dcWriteReq && rst) begin
                    accept   = 1'b1;
                    addr_d   = bus.dcWriteAddr;
                    data_d   = bus.dcWriteData;
                    be_d     = bus.dcWriteByteWE;
                    tagIndex = bus.dcWriteAddr[OFFSET_WIDTH +: INDEX_WIDTH];
                    state_d  = bus.dcWriteUncachable ? UC_WRITE : TAG;
                end
            end
            TAG: begin
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
                state_d = tagHit ? WRITE : MISS_ALLOC;
`else
                state_d = tagHit ? WRITE : UC_WRITE;
`endif
            end
            WRITE: begin
                writeLine = 1'b1;
                writeDone = 1'b1;
                state_d   = IDLE;
            end
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
            MISS_ALLOC: begin
                allocReq = 1'b1;
                if (bus.mshrAllocAck) begin
                    fillSeen_d = bus.mshrFillDone;
                    state_d    = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (fillSeen_q || bus.mshrFillDone) begin
                    fillSeen_d = 1'b0;
                    state_d    = RETAG;
                end
            end
            RETAG: begin
                tagIndex = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
                state_d  = TAG;
            end
`endif
            UC_WRITE: begin
                memReq = 1'b1;
                if (bus.memWriteAck) begin
                    writeDone = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
            fillSeen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
            fillSeen_q <= fillSeen_d;
`endif
        end
    end

    assign bus.dcWriteReqAck = accept;
    assign bus.dcWriteBusy   = (state_q != IDLE);
    assign bus.dcWriteHit    = writeDone;
    assign bus.tagReadIndex  = tagIndex;

    // Payload outputs are zero unless their strobe is active, so stale requests never leak out.
    assign bus.dataWE          = writeLine;
    assign bus.dataWriteIndex  = writeLine ? addr_q[OFFSET_WIDTH +: INDEX_WIDTH] : '0;
    assign bus.dataWriteData   = writeLine ? data_q : '0;
    assign bus.dataWriteByteWE = writeLine ? be_q : '0;

    assign bus.mshrAllocReq  = allocReq;
    assign bus.mshrAllocAddr = allocReq ? {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} : '0;

    assign bus.memWriteReq    = memReq;
    assign bus.memWriteAddr   = memReq ? addr_q : '0;
    assign bus.memWriteData   = memReq ? data_q : '0;
    assign bus.memWriteByteWE = memReq ? be_q : '0;
endmodule

// File: tb/tb_dcache_write_responder.sv
// Self-checking bench for dcache_write_responder: directed scenarios plus randomized requests
// checked against a per-request timing plan; follows RSD_DCACHE_WRITE_ALLOCATE_EN like the RTL.
module tb_dcache_write_responder;
    localparam logic [5:0] ACK   = 6'b100000;
    localparam logic [5:0] BUSY  = 6'b010000;
    localparam logic [5:0] HIT   = 6'b001000;
    localparam logic [5:0] DWE   = 6'b000100;
    localparam logic [5:0] ALLOC = 6'b000010;
    localparam logic [5:0] MEM   = 6'b000001;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [22:0] tagMem [64];

    dcache_write_responder_if bus ();

    dcache_write_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read tag array: data follows the index by one clock.
    always @(posedge clk) bus.tagReadData <= tagMem[bus.tagReadIndex];

    function automatic logic [5:0] ctl();
        return {bus.dcWriteReqAck, bus.dcWriteBusy, bus.dcWriteHit,
                bus.dataWE, bus.mshrAllocReq, bus.memWriteReq};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if (ctl() !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl(), 6'b0);
        end
        total++;
        if ({bus.tagReadIndex, bus.dataWriteIndex, bus.dataWriteData, bus.mshrAllocAddr,
             bus.memWriteAddr, bus.memWriteData} !== '0) begin
            bad++; $display("[TB] FAIL reset_payload: got nonzero want zero");
        end
        rst = 1'b1;
        @(negedge clk); #1;
        total++;
        if (ctl() !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_release_ctl: got %b want %b", ctl(), 6'b0);
        end
        @(negedge clk);
    endtask

    task automatic test_hit();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        tagMem[4] = {1'b1, 22'h4};
        bus.dcWriteReq = 1'b1; bus.dcWriteAddr = 32'h0000_1040; bus.dcWriteData = d;
        bus.dcWriteByteWE = 16'h000F; bus.dcWriteUncachable = 1'b0;
        #1;
        total++;
        if (ctl() !== ACK) begin bad++; $display("[TB] FAIL hit_c0_ctl: got %b want %b", ctl(), ACK); end
        total++;
        if (bus.tagReadIndex !== 6'd4) begin
            bad++; $display("[TB] FAIL hit_c0_index: got %0d want 4", bus.tagReadIndex);
        end
        @(negedge clk); bus.dcWriteReq = 1'b0; #1;
        total++;
        if (ctl() !== BUSY) begin bad++; $display("[TB] FAIL hit_c1_ctl: got %b want %b", ctl(), BUSY); end
        @(negedge clk); #1;
        total++;
        if (ctl() !== (BUSY | HIT | DWE)) begin
            bad++; $display("[TB] FAIL hit_c2_ctl: got %b want %b", ctl(), BUSY | HIT | DWE);
        end
        total++;
        if ({bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE} !== {6'd4, d, 16'h000F}) begin
            bad++; $display("[TB] FAIL hit_c2_data: got %h/%h/%h want 04/%h/000f",
                            bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE, d);
        end
        @(negedge clk); #1;
        total++;
        if (ctl() !== 6'b0) begin bad++; $display("[TB] FAIL hit_c3_ctl: got %b want 000000", ctl()); end
        @(negedge clk);
    endtask

    task automatic test_miss();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        tagMem[4] = '0;
        bus.dcWriteReq = 1'b1; bus.dcWriteAddr = 32'h0000_1040; bus.dcWriteData = d;
        bus.dcWriteByteWE = 16'h00F0; bus.dcWriteUncachable = 1'b0;
        #1;
        total++;
        if (ctl() !== ACK) begin bad++; $display("[TB] FAIL miss_c0_ctl: got %b want %b", ctl(), ACK); end
        @(negedge clk); bus.dcWriteReq = 1'b0; #1;
        total++;
        if (ctl() !== BUSY) begin bad++; $display("[TB] FAIL miss_c1_ctl: got %b want %b", ctl(), BUSY); end
        @(negedge clk);
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
        bus.memWriteAck = 1'b1;
        for (int c = 2; c <= 12; c++) begin
            logic [5:0] exp;
            bus.mshrAllocAck = (c == 4);
            bus.mshrFillDone = (c == 9);
            if (c == 9) tagMem[4] = {1'b1, 22'h4};
            exp = BUSY;
            if (c <= 4) exp |= ALLOC;
            if (c == 12) exp |= HIT | DWE;
            #1;
            total++;
            if (ctl() !== exp) begin
                bad++; $display("[TB] FAIL miss_alloc_c%0d_ctl: got %b want %b", c, ctl(), exp);
            end
            if (c <= 4) begin
                total++;
                if (bus.mshrAllocAddr !== 32'h0000_1040) begin
                    bad++; $display("[TB] FAIL miss_alloc_addr: got %h want 00001040", bus.mshrAllocAddr);
                end
            end
            if (c == 10) begin
                total++;
                if (bus.tagReadIndex !== 6'd4) begin
                    bad++; $display("[TB] FAIL miss_retag_index: got %0d want 4", bus.tagReadIndex);
                end
            end
            if (c == 12) begin
                total++;
                if ({bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE} !== {6'd4, d, 16'h00F0}) begin
                    bad++; $display("[TB] FAIL miss_write_data: got %h/%h/%h want 04/%h/00f0",
                                    bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE, d);
                end
            end
            @(negedge clk);
        end
        bus.memWriteAck = 1'b0; bus.mshrAllocAck = 1'b0; bus.mshrFillDone = 1'b0;
`else
        for (int c = 2; c <= 4; c++) begin
            bus.memWriteAck = (c == 4);
            #1;
            total++;
            if (ctl() !== (BUSY | MEM | ((c == 4) ? HIT : 6'b0))) begin
                bad++; $display("[TB] FAIL miss_wt_c%0d_ctl: got %b", c, ctl());
            end
            total++;
            if ({bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE} !== {32'h0000_1040, d, 16'h00F0}) begin
                bad++; $display("[TB] FAIL miss_wt_payload: got %h/%h/%h want 00001040/%h/00f0",
                                bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE, d);
            end
            @(negedge clk);
        end
        bus.memWriteAck = 1'b0;
`endif
        #1;
        total++;
        if (ctl() !== 6'b0) begin bad++; $display("[TB] FAIL miss_end_ctl: got %b want 000000", ctl()); end
        @(negedge clk);
    endtask

    task automatic test_uncachable();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        tagMem[0] = {1'b1, 22'h3C0000};
        bus.dcWriteReq = 1'b1; bus.dcWriteAddr = 32'hF000_0000; bus.dcWriteData = d;
        bus.dcWriteByteWE = 16'hFFFF; bus.dcWriteUncachable = 1'b1;
        #1;
        total++;
        if (ctl() !== ACK) begin bad++; $display("[TB] FAIL uc_c0_ctl: got %b want %b", ctl(), ACK); end
        @(negedge clk);
        bus.dcWriteReq = 1'b0; bus.dcWriteUncachable = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            bus.memWriteAck = (c == 4);
            #1;
            total++;
            if (ctl() !== (BUSY | MEM | ((c == 4) ? HIT : 6'b0))) begin
                bad++; $display("[TB] FAIL uc_c%0d_ctl: got %b", c, ctl());
            end
            total++;
            if ({bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE} !== {32'hF000_0000, d, 16'hFFFF}) begin
                bad++; $display("[TB] FAIL uc_payload: got %h/%h/%h want f0000000/%h/ffff",
                                bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE, d);
            end
            @(negedge clk);
        end
        bus.memWriteAck = 1'b0;
        #1;
        total++;
        if (ctl() !== 6'b0) begin bad++; $display("[TB] FAIL uc_end_ctl: got %b want 000000", ctl()); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d1, d2;
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        tagMem[4] = {1'b1, 22'h4};
        tagMem[5] = {1'b1, 22'h8};
        bus.dcWriteReq = 1'b1; bus.dcWriteAddr = 32'h0000_1040; bus.dcWriteData = d1;
        bus.dcWriteByteWE = 16'h0F0F; bus.dcWriteUncachable = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            logic [5:0] exp;
            if (c == 1) begin
                bus.dcWriteAddr = 32'h0000_2050; bus.dcWriteData = d2; bus.dcWriteByteWE = 16'hF000;
            end
            if (c == 4) bus.dcWriteReq = 1'b0;
            case (c)
                0, 3:    exp = ACK;
                1, 4:    exp = BUSY;
                2, 5:    exp = BUSY | HIT | DWE;
                default: exp = 6'b0;
            endcase
            #1;
            total++;
            if (ctl() !== exp) begin
                bad++; $display("[TB] FAIL b2b_c%0d_ctl: got %b want %b", c, ctl(), exp);
            end
            if (c == 2 || c == 5) begin
                total++;
                if ({bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE} !==
                    ((c == 2) ? {6'd4, d1, 16'h0F0F} : {6'd5, d2, 16'hF000})) begin
                    bad++; $display("[TB] FAIL b2b_c%0d_data: got %h/%h/%h", c,
                                    bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE);
                end
            end
            if (c == 3) begin
                total++;
                if (bus.tagReadIndex !== 6'd5) begin
                    bad++; $display("[TB] FAIL b2b_c3_index: got %0d want 5", bus.tagReadIndex);
                end
            end
            @(negedge clk);
        end
    endtask

    // Reset lands while the responder waits on an external agent; the late response must be ignored.
    task automatic test_reset_in_wait();
        tagMem[6] = '0;
        bus.dcWriteReq = 1'b1; bus.dcWriteAddr = 32'h0000_1060; bus.dcWriteData = '1;
        bus.dcWriteByteWE = 16'hFFFF; bus.dcWriteUncachable = 1'b0;
        @(negedge clk); bus.dcWriteReq = 1'b0;
        @(negedge clk);
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
        bus.mshrAllocAck = 1'b1;
        @(negedge clk); bus.mshrAllocAck = 1'b0; #1;
        total++;
        if (ctl() !== BUSY) begin bad++; $display("[TB] FAIL rst_wait_ctl: got %b want %b", ctl(), BUSY); end
        @(negedge clk);
`endif
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.mshrFillDone = (c == 0);
            bus.memWriteAck  = (c == 0);
            #1;
            total++;
            if (ctl() !== 6'b0) begin
                bad++; $display("[TB] FAIL rst_after_c%0d_ctl: got %b want 000000", c, ctl());
            end
            total++;
            if ({bus.tagReadIndex, bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE,
                 bus.mshrAllocAddr, bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE} !== '0) begin
                bad++; $display("[TB] FAIL rst_after_c%0d_payload: got nonzero want zero", c);
            end
            @(negedge clk);
        end
        bus.mshrFillDone = 1'b0; bus.memWriteAck = 1'b0;
    endtask

    task automatic test_random();
        logic [21:0]  tg;
        logic [5:0]   ix;
        logic [31:0]  a;
        logic [127:0] d;
        logic [15:0]  be;
        logic         uc, isHit;
        logic [5:0]   exp;
        int           memStart, memAck, allocAck, fillAt, writeAt, done;
        for (int i = 0; i < 8; i++) tagMem[i] = {1'($urandom_range(0, 1)), 22'($urandom_range(0, 3))};
        for (int n = 0; n < 40; n++) begin
            tg = 22'($urandom_range(0, 3));
            ix = 6'($urandom_range(0, 7));
            uc = ($urandom_range(0, 3) == 0);
            a  = uc ? $urandom : {tg, ix, 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            be = 16'($urandom);
            isHit = !uc && tagMem[ix][22] && (tagMem[ix][21:0] == tg);
            memStart = -1; memAck = -1; allocAck = -1; fillAt = -1; writeAt = -1;
            if (uc) memStart = 1;
            else if (isHit) writeAt = 2;
            else begin
`ifdef RSD_DCACHE_WRITE_ALLOCATE_EN
                allocAck = 2 + int'($urandom_range(0, 3));
                fillAt   = allocAck + int'($urandom_range(0, 4));
                writeAt  = ((fillAt == allocAck) ? allocAck + 1 : fillAt) + 3;
`else
                memStart = 2;
`endif
            end
            if (memStart >= 0) begin
                memAck = memStart + int'($urandom_range(0, 3));
                done   = memAck;
            end else begin
                done = writeAt;
            end
            bus.dcWriteAddr = a; bus.dcWriteData = d; bus.dcWriteByteWE = be; bus.dcWriteUncachable = uc;
            for (int c = 0; c <= done + 1; c++) begin
                bus.dcWriteReq   = (c == 0);
                bus.memWriteAck  = (memAck >= 0) ? (c == memAck) : 1'($urandom);
                bus.mshrAllocAck = (allocAck >= 0) ? (c == allocAck) : 1'($urandom);
                bus.mshrFillDone = (fillAt >= 0) ? (c == fillAt) : 1'($urandom);
                if (c == fillAt) tagMem[ix] = {1'b1, tg};
                exp = 6'b0;
                if (c == 0) exp = ACK;
                else if (c <= done) begin
                    exp = BUSY;
                    if (c == writeAt) exp |= HIT | DWE;
                    if (memStart >= 0 && c >= memStart) exp |= MEM;
                    if (c == memAck) exp |= HIT;
                    if (allocAck >= 0 && c >= 2 && c <= allocAck) exp |= ALLOC;
                end
                #1;
                total++;
                if (ctl() !== exp) begin
                    bad++; $display("[TB] FAIL rand_ctl req%0d c%0d: got %b want %b", n, c, ctl(), exp);
                end
                if (c == 0) begin
                    total++;
                    if (bus.tagReadIndex !== a[9:4]) begin
                        bad++; $display("[TB] FAIL rand_index req%0d: got %0d want %0d", n, bus.tagReadIndex, a[9:4]);
                    end
                end
                if (exp[2]) begin
                    total++;
                    if ({bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE} !== {ix, d, be}) begin
                        bad++; $display("[TB] FAIL rand_data req%0d: got %h/%h/%h want %h/%h/%h", n,
                                        bus.dataWriteIndex, bus.dataWriteData, bus.dataWriteByteWE, ix, d, be);
                    end
                end
                if (exp[0]) begin
                    total++;
                    if ({bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE} !== {a, d, be}) begin
                        bad++; $display("[TB] FAIL rand_mem req%0d: got %h/%h/%h want %h/%h/%h", n,
                                        bus.memWriteAddr, bus.memWriteData, bus.memWriteByteWE, a, d, be);
                    end
                end
                if (exp[1]) begin
                    total++;
                    if (bus.mshrAllocAddr !== {a[31:4], 4'h0}) begin
                        bad++; $display("[TB] FAIL rand_alloc req%0d: got %h want %h", n,
                                        bus.mshrAllocAddr, {a[31:4], 4'h0});
                    end
                end
                @(negedge clk);
            end
        end
        bus.dcWriteReq = 1'b0; bus.memWriteAck = 1'b0; bus.mshrAllocAck = 1'b0; bus.mshrFillDone = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.dcWriteReq = 1'b0; bus.dcWriteAddr = '0; bus.dcWriteData = '0;
        bus.dcWriteByteWE = '0; bus.dcWriteUncachable = 1'b0;
        bus.mshrAllocAck = 1'b0; bus.mshrFillDone = 1'b0; bus.memWriteAck = 1'b0;
        for (int i = 0; i < 64; i++) tagMem[i] = '0;
        test_reset();
        test_hit();
        test_miss();
        test_uncachable();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
